// File: rtl/alu_sequencer_legv8_if.sv
// alu_sequencer_legv8_if
// Request/response channel between the execute control (master) and the
// ALU sequencer (slave).
//   req_valid/req_ready : request handshake
//   req_mul             : 1 = multiply, 0 = single ALU op
//   req_fs, req_c0      : ALU function select and carry-in (single op only)
//   req_a, req_b        : operands (MUL: A multiplicand, B multiplier)
//   rsp_valid/rsp_ready : response handshake
//   rsp_f, rsp_status   : result and ALU status (status is 0 for MUL)
interface alu_sequencer_legv8_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_mul;
  logic [4:0]  req_fs;
  logic        req_c0;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_f;
  logic [3:0]  rsp_status;

  modport master (
    output req_valid, req_mul, req_fs, req_c0, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_status
  );

  modport slave (
    input  req_valid, req_mul, req_fs, req_c0, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_status
  );
endinterface

// File: rtl/alu_sequencer_legv8.sv
// alu_sequencer_legv8
// Owns the single ALU_LEGv8 instance and sequences it for one requester:
// either a one-cycle pass-through ALU operation or a 64-bit multiply built
// as an iterative shift-add that only uses the ALU's ADD function.
// Ports:
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   bus            : request/response channel (slave modport)
//   busy           : high whenever the sequencer is not idle
//   alu_a/b/fs/c0  : operands, function select and carry-in to the ALU
//   alu_f/status   : result and status from the ALU
// Parameter MUL_BITS (1..64): number of multiplier bits processed per MUL.
// Optional macro ALU_SEQ_EARLY_EXIT_EN: a MUL finishes as soon as the
// remaining multiplier bits are all zero.
module alu_sequencer_legv8 #(
  parameter int MUL_BITS = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_sequencer_legv8_if.slave bus,
  output logic                 busy,
  output logic [63:0]          alu_a,
  output logic [63:0]          alu_b,
  output logic [4:0]           alu_fs,
  output logic                 alu_c0,
  input  logic [63:0]          alu_f,
  input  logic [3:0]           alu_status
);

  typedef enum logic [2:0] {IDLE, OP, MADD, MDBL, RESP} state_t;

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [6:0] LAST_CNT = 7'(MUL_BITS);

  state_t      state_q, state_d;
  // opA doubles as the multiplicand M and opB as the multiplier Q during MUL
  logic [63:0] opA_q, opA_d;
  logic [63:0] opB_q, opB_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  fs_q, fs_d;
  logic        c0_q, c0_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] rspF_q, rspF_d;
  logic [3:0]  rspStatus_q, rspStatus_d;
  logic [6:0]  cntInc;
  logic        earlyExit;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign earlyExit = (opB_q == 64'd0);
`else
  assign earlyExit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      prod_q      <= '0;
      fs_q        <= '0;
      c0_q        <= 1'b0;
      cnt_q       <= '0;
      rspF_q      <= '0;
      rspStatus_q <= '0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      prod_q      <= prod_d;
      fs_q        <= fs_d;
      c0_q        <= c0_d;
      cnt_q       <= cnt_d;
      rspF_q      <= rspF_d;
      rspStatus_q <= rspStatus_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    prod_d        = prod_q;
    fs_d          = fs_q;
    c0_d          = c0_q;
    cnt_d         = cnt_q;
    rspF_d        = rspF_q;
    rspStatus_d   = rspStatus_q;
    cntInc        = cnt_q + 7'd1;
    alu_a         = '0;
    alu_b         = '0;
    alu_fs        = '0;
    alu_c0        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          opA_d   = bus.req_a;
          opB_d   = bus.req_b;
          fs_d    = bus.req_fs;
          c0_d    = bus.req_c0;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = bus.req_mul ? MADD : OP;
        end
      end
      OP: begin
        alu_a       = opA_q;
        alu_b       = opB_q;
        alu_fs      = fs_q;
        alu_c0      = c0_q;
        rspF_d      = alu_f;
        rspStatus_d = alu_status;
        state_d     = RESP;
      end
      MADD: begin
        // P + M; only kept when the current multiplier bit is set
        alu_a  = prod_q;
        alu_b  = opA_q;
        alu_fs = FS_ADD;
        if (earlyExit) begin
          rspF_d      = prod_q;
          rspStatus_d = '0;
          state_d     = RESP;
        end else begin
          if (opB_q[0]) begin
            prod_d = alu_f;
          end
          state_d = MDBL;
        end
      end
      MDBL: begin
        // M + M doubles the multiplicand; bit 63 carry is dropped (mod 2^64)
        alu_a  = opA_q;
        alu_b  = opA_q;
        alu_fs = FS_ADD;
        opA_d  = alu_f;
        opB_d  = opB_q >> 1;
        cnt_d  = cntInc;
        if (cntInc == LAST_CNT) begin
          rspF_d      = prod_q;
          rspStatus_d = '0;
          state_d     = RESP;
        end else begin
          state_d = MADD;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_f      = rspF_q;
  assign bus.rsp_status = rspStatus_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/alu_sequencer_legv8.md
# alu_sequencer_legv8

Owns the single ALU_LEGv8 instance and sequences it on behalf of one requester. It accepts either a single ALU operation, which is passed through for one cycle, or a 64-bit multiply. The multiply is built as an iterative shift-add that uses only the ALU's ADD function. Results return on a valid/ready response channel, and the block sits between the core's execute control and the ALU.

## Interface
- `MUL_BITS`, default 64: number of multiplier bits processed per MUL, from the LSB up; legal range 1..64.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_mul`  in  1  1 = multiply (`req_a` × `req_b`); 0 = single ALU op.
- `req_fs`  in  5  ALU function select; single op only.
- `req_c0`  in  1  ALU carry-in; single op only.
- `req_a`, `req_b`  in  64  operands; for MUL, A is the multiplicand and B the multiplier.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_f`  out  64  result.
- `rsp_status`  out  4  ALU status for a single op; 4'b0000 for MUL.
- `busy`  out  1  state ≠ IDLE.
- `alu_a`, `alu_b`  out  64  to ALU A/B.
- `alu_fs`  out  5  to ALU FS.
- `alu_c0`  out  1  to ALU C0.
- `alu_f`  in  64  from ALU F.
- `alu_status`  in  4  from ALU status.

## Operation
- States are IDLE, OP, MADD, MDBL and RESP.
- `req_ready` = (state == IDLE). A request is accepted on an edge with `req_valid` & `req_ready`, and all request fields are registered at that edge.
- **IDLE:** `alu_a` = 0, `alu_b` = 0, `alu_fs` = 5'b00000, `alu_c0` = 0.
- **Single op (`req_mul` = 0):** IDLE→OP.
  - In OP, `alu_*` are driven from the registered A, B, FS and C0.
  - At the end of OP, `alu_f`/`alu_status` are captured into `rsp_f`/`rsp_status`, then OP→RESP.
- **MUL (`req_mul` = 1):** on accept, P = 0, M = `req_a`, Q = `req_b`, count = 0; IDLE→MADD.
- **MADD:** `alu_a` = P, `alu_b` = M, `alu_fs` = 5'b01000 (ADD), `alu_c0` = 0.
  - If Q[0] = 1, P ← `alu_f` at the edge; otherwise P is held.
  - MADD→MDBL.
- **MDBL:** `alu_a` = M, `alu_b` = M, `alu_fs` = 5'b01000, `alu_c0` = 0.
  - At the edge: M ← `alu_f`, Q ← Q >> 1 (logical, done locally), count ← count + 1.
  - If count + 1 == `MUL_BITS`, go to RESP with `rsp_f` = P and `rsp_status` = 0. Otherwise go to MADD.
- **Arithmetic:** the product is modulo 2^64; carries out of bit 63 are discarded, and ALU carry/overflow flags are ignored during MUL.
- **RESP:** `rsp_valid` = 1, and `rsp_f`/`rsp_status` are held stable until `rsp_valid` & `rsp_ready`, then RESP→IDLE. `req_ready` is not asserted in the RESP cycle (no same-cycle turnaround).
- **Reset:** while `reset_n` = 0 at an edge, the state goes to IDLE and any in-flight operation is discarded.

## Timing
- **Reset values:** `req_ready` = 1 (IDLE), `rsp_valid` = 0, `rsp_f` = 0, `rsp_status` = 0, `busy` = 0, `alu_*` = 0. P, M, Q and count are 0.
- **Single-op latency:** accept edge E0; `rsp_valid` is high from edge E1 (1 cycle).
- **MUL latency:** `rsp_valid` is high 2·`MUL_BITS` edges after accept; 128 for the default.
- **Back-to-back:** the next accept is earliest on the edge after the response handshake.
- **Request changes:** `req_*` changes after accept have no effect.
- **Response consumption:** a `rsp_ready` held high is consumed on the first RESP edge; `rsp_valid` is high for exactly one cycle.

## Configuration
- `ALU_SEQ_EARLY_EXIT_EN` defined:
  - On entering MADD with Q == 0, the block goes MADD→RESP in that single cycle, with P unchanged and no ALU use.
  - MUL latency = 2·(index of the highest set multiplier bit + 1) + 1 cycles, capped at 2·`MUL_BITS`.
  - Q == 0 gives a latency of 1.
- Undefined: there is no zero check, and MUL latency is always 2·`MUL_BITS`.

## Test plan
1. Single op, A = 64'h6, B = 64'h3, FS = 5'b00000, C0 = 0 → `rsp_f` = 64'h2 one edge after accept, with `rsp_status` = `alu_status` from that cycle.
2. MUL 7 × 9 → `rsp_f` = 64'd63, `rsp_status` = 0.
   - Without the macro: `rsp_valid` 128 cycles after accept.
   - With the macro: 9 cycles after accept.
3. MUL 64'hFFFF_FFFF_FFFF_FFFF × 2 → `rsp_f` = 64'hFFFF_FFFF_FFFF_FFFE (wrap).
4. Backpressure: hold `rsp_ready` = 0 for 10 cycles after `rsp_valid` → `rsp_f` is stable and `req_ready` = 0 throughout. On release → IDLE on the next edge.
5. Reset: `reset_n` low for 1 edge at cycle 20 of a MUL → all outputs at reset values. A subsequent MUL 3 × 5 → 15.
6. MUL X × 0 with `ALU_SEQ_EARLY_EXIT_EN` → `rsp_f` = 0, `rsp_valid` 1 edge after accept, and `alu_fs` stays 0 except during the MADD cycle.
